// File: rtl/ir_car_scheduler.sv
// ---------------------------------------------------------------------------
// ir_car_scheduler
//
// Round-robin IR send scheduler. Holds one latched command per car. On each
// period tick it issues one packet per enabled car, in ascending car order,
// and hands each packet to the IR transmitter state machine. A per-car
// watchdog clears a car's command to 0 (stop) if it is not rewritten within
// TIMEOUT_TICKS period ticks.
//
// Ports:
//   clk_i            system clock
//   reset_ni         asynchronous, active-low reset
//   wr_en_i          command write strobe
//   wr_car_i         car index for the write
//   wr_cmd_i         command value for the write
//   enable_mask_i    bit i = 1 schedules car i in the next round
//   period_tick_i    one-cycle pulse that starts a round
//   tx_busy_i        transmitter busy (high while a packet is on air)
//   clr_flags_i      clears the sticky flags
//   tx_start_o       one-cycle send request
//   tx_car_o         car being sent (held until the next send)
//   tx_cmd_o         command being sent (held until the next send)
//   overrun_o        sticky: a tick arrived while a round was running
//   no_ack_o         sticky: the transmitter failed to go busy
//   round_active_o   high from round start until return to idle
// ---------------------------------------------------------------------------
module ir_car_scheduler #(
    parameter int CAR_COUNT     = 4,
    parameter int CMD_LEN       = 4,
    parameter int TIMEOUT_TICKS = 10,
    parameter int ACK_CYCLES    = 16,
    localparam int CW           = $clog2(CAR_COUNT)
) (
    input  logic                 clk_i,
    input  logic                 reset_ni,
    input  logic                 wr_en_i,
    input  logic [CW-1:0]        wr_car_i,
    input  logic [CMD_LEN-1:0]   wr_cmd_i,
    input  logic [CAR_COUNT-1:0] enable_mask_i,
    input  logic                 period_tick_i,
    input  logic                 tx_busy_i,
    input  logic                 clr_flags_i,
    output logic                 tx_start_o,
    output logic [CW-1:0]        tx_car_o,
    output logic [CMD_LEN-1:0]   tx_cmd_o,
    output logic                 overrun_o,
    output logic                 no_ack_o,
    output logic                 round_active_o
);

    localparam int AW  = $clog2(TIMEOUT_TICKS + 1);
    localparam int ACW = $clog2(ACK_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SCAN,
        S_START,
        S_WAIT_ACK,
        S_WAIT_DONE
    } state_t;

    state_t                 state_q;
    logic [CAR_COUNT-1:0]   pending_q;
    logic [CW-1:0]          idx_q;
    logic [ACW-1:0]         ack_cnt_q;
    logic                   tx_start_q;
    logic [CW-1:0]          tx_car_q;
    logic [CMD_LEN-1:0]     tx_cmd_q;
    logic                   overrun_q;
    logic                   no_ack_q;
    logic                   round_active_q;

    logic [CMD_LEN-1:0]     cmd_all [CAR_COUNT];

    // -----------------------------------------------------------------------
    // Per-car command latch and watchdog age counter. A write always beats
    // the ageing tick in the same cycle. The age saturates at TIMEOUT_TICKS,
    // and the command is forced to stop on the tick that reaches it.
    // -----------------------------------------------------------------------
    for (genvar gi = 0; gi < CAR_COUNT; gi++) begin : g_car
        logic [CMD_LEN-1:0] cmd_q;
        logic [AW-1:0]      age_q;
        logic               wr_hit;

        assign wr_hit = wr_en_i && (wr_car_i == CW'(gi));

        always_ff @(posedge clk_i or negedge reset_ni) begin
            if (!reset_ni) begin
                cmd_q <= '0;
                age_q <= '0;
            end else if (wr_hit) begin
                cmd_q <= wr_cmd_i;
                age_q <= '0;
            end else if (period_tick_i && (age_q < AW'(TIMEOUT_TICKS))) begin
                age_q <= age_q + 1'b1;
                if (age_q == AW'(TIMEOUT_TICKS - 1)) begin
                    cmd_q <= '0;
                end
            end
        end

        assign cmd_all[gi] = cmd_q;
    end

    // -----------------------------------------------------------------------
    // Lowest pending car at or above the current index. Cars below idx have
    // already been served (or skipped) this round, so a round never revisits.
    // -----------------------------------------------------------------------
    logic          found_d;
    logic [CW-1:0] found_idx_d;

    always_comb begin
        found_d     = 1'b0;
        found_idx_d = '0;
        for (int i = 0; i < CAR_COUNT; i++) begin
            if (!found_d && pending_q[i] && (i >= int'(idx_q))) begin
                found_d     = 1'b1;
                found_idx_d = CW'(i);
            end
        end
    end

    logic ack_expire_d;
    assign ack_expire_d = (state_q == S_WAIT_ACK) && !tx_busy_i &&
                          (ack_cnt_q == ACW'(ACK_CYCLES - 1));

    // -----------------------------------------------------------------------
    // Round sequencer with registered outputs.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q        <= S_IDLE;
            pending_q      <= '0;
            idx_q          <= '0;
            ack_cnt_q      <= '0;
            tx_start_q     <= 1'b0;
            tx_car_q       <= '0;
            tx_cmd_q       <= '0;
            overrun_q      <= 1'b0;
            no_ack_q       <= 1'b0;
            round_active_q <= 1'b0;
        end else begin
            tx_start_q <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    // An empty snapshot never starts a round.
                    if (period_tick_i && (enable_mask_i != '0)) begin
                        pending_q      <= enable_mask_i;
                        idx_q          <= '0;
                        round_active_q <= 1'b1;
                        state_q        <= S_SCAN;
                    end
                end

                S_SCAN: begin
                    if (found_d) begin
                        idx_q      <= found_idx_d;
                        tx_start_q <= 1'b1;
                        tx_car_q   <= found_idx_d;
                        tx_cmd_q   <= cmd_all[found_idx_d];
                        state_q    <= S_START;
                    end else begin
                        round_active_q <= 1'b0;
                        state_q        <= S_IDLE;
                    end
                end

                S_START: begin
                    ack_cnt_q <= '0;
                    state_q   <= S_WAIT_ACK;
                end

                S_WAIT_ACK: begin
                    if (tx_busy_i) begin
                        state_q <= S_WAIT_DONE;
                    end else if (ack_expire_d) begin
                        // Skip this car; the scan moves past it because
                        // its pending bit is now clear.
                        pending_q[idx_q] <= 1'b0;
                        state_q          <= S_SCAN;
                    end else begin
                        ack_cnt_q <= ack_cnt_q + 1'b1;
                    end
                end

                S_WAIT_DONE: begin
                    if (!tx_busy_i) begin
                        pending_q[idx_q] <= 1'b0;
                        idx_q            <= idx_q + 1'b1;
                        state_q          <= S_SCAN;
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase

            // Sticky flags: a set event in the same cycle beats the clear.
            if (period_tick_i && (state_q != S_IDLE)) begin
                overrun_q <= 1'b1;
            end else if (clr_flags_i) begin
                overrun_q <= 1'b0;
            end

            if (ack_expire_d) begin
                no_ack_q <= 1'b1;
            end else if (clr_flags_i) begin
                no_ack_q <= 1'b0;
            end
        end
    end

    assign tx_start_o     = tx_start_q;
    assign tx_car_o       = tx_car_q;
    assign tx_cmd_o       = tx_cmd_q;
    assign overrun_o      = overrun_q;
    assign no_ack_o       = no_ack_q;
    assign round_active_o = round_active_q;

endmodule

// File: tb/tb_ir_car_scheduler.sv
// ---------------------------------------------------------------------------
// tb_ir_car_scheduler
//
// Directed bench for ir_car_scheduler (default parameters: 4 cars, 4-bit
// commands, 10-tick watchdog, 16-cycle ack window). A small transmitter
// model raises busy for busy_len cycles after each send request when
// enabled; a logger records every send request for sequence checks.
// ---------------------------------------------------------------------------
module tb_ir_car_scheduler;

    logic       clk;
    logic       rst_n;
    logic       wr_en;
    logic [1:0] wr_car;
    logic [3:0] wr_cmd;
    logic [3:0] mask;
    logic       tick;
    logic       tx_busy;
    logic       clr;
    logic       tx_start;
    logic [1:0] tx_car;
    logic [3:0] tx_cmd;
    logic       overrun;
    logic       no_ack;
    logic       round_active;

    int n_cmp = 0;
    int n_bad = 0;

    int busy_en  = 0;
    int busy_len = 3;
    int busy_cnt = 0;

    int log_car [$];
    int log_cmd [$];

    ir_car_scheduler dut (
        .clk_i          (clk),
        .reset_ni       (rst_n),
        .wr_en_i        (wr_en),
        .wr_car_i       (wr_car),
        .wr_cmd_i       (wr_cmd),
        .enable_mask_i  (mask),
        .period_tick_i  (tick),
        .tx_busy_i      (tx_busy),
        .clr_flags_i    (clr),
        .tx_start_o     (tx_start),
        .tx_car_o       (tx_car),
        .tx_cmd_o       (tx_cmd),
        .overrun_o      (overrun),
        .no_ack_o       (no_ack),
        .round_active_o (round_active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic write_cmd(input int car, input int cmd);
        wr_en  = 1'b1;
        wr_car = 2'(car);
        wr_cmd = 4'(cmd);
        step(1);
        wr_en  = 1'b0;
    endtask

    task automatic pulse_tick();
        tick = 1'b1;
        step(1);
        tick = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (round_active && n < budget) begin
            step(1);
            n++;
        end
        check("round_end_in_budget", {31'd0, round_active}, 32'd0);
    endtask

    task automatic clear_log();
        log_car.delete();
        log_cmd.delete();
    endtask

    // Transmitter model: busy for busy_len cycles after each send request.
    initial begin
        tx_busy = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                tx_busy  = 1'b0;
                busy_cnt = 0;
            end else if (busy_cnt > 0) begin
                busy_cnt--;
                if (busy_cnt == 0) tx_busy = 1'b0;
            end else if (busy_en != 0 && tx_start) begin
                tx_busy  = 1'b1;
                busy_cnt = busy_len;
            end
        end
    end

    // Send request logger.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (tx_start) begin
                log_car.push_back(int'(tx_car));
                log_cmd.push_back(int'(tx_cmd));
            end
        end
    end

    initial begin
        rst_n  = 1'b0;
        wr_en  = 1'b0;
        wr_car = '0;
        wr_cmd = '0;
        mask   = '0;
        tick   = 1'b0;
        clr    = 1'b0;

        // ---- reset state ----
        step(2);
        check("rst_tx_start", {31'd0, tx_start}, 0);
        check("rst_tx_car", {30'd0, tx_car}, 0);
        check("rst_tx_cmd", {28'd0, tx_cmd}, 0);
        check("rst_overrun", {31'd0, overrun}, 0);
        check("rst_no_ack", {31'd0, no_ack}, 0);
        check("rst_round_active", {31'd0, round_active}, 0);
        rst_n = 1'b1;
        step(1);

        // ---- single car: latency and round end ----
        write_cmd(2, 5);
        mask     = 4'b0100;
        busy_en  = 1;
        busy_len = 20;
        clear_log();
        pulse_tick();                       // now in the SCAN cycle
        check("t1_scan_ra", {31'd0, round_active}, 1);
        check("t1_scan_no_start", {31'd0, tx_start}, 0);
        step(1);                            // START cycle, tick + 2
        check("t1_start", {31'd0, tx_start}, 1);
        check("t1_car", {30'd0, tx_car}, 2);
        check("t1_cmd", {28'd0, tx_cmd}, 5);
        step(1);
        check("t1_start_one_cycle", {31'd0, tx_start}, 0);
        step(20);                           // busy seen low here -> SCAN
        check("t1_ra_still_high", {31'd0, round_active}, 1);
        step(1);
        check("t1_ra_dropped", {31'd0, round_active}, 0);
        check("t1_n_starts", log_car.size(), 1);

        // ---- mask 1011: cars 0,1,3 in order ----
        write_cmd(0, 1);
        write_cmd(1, 2);
        write_cmd(2, 3);
        write_cmd(3, 4);
        mask     = 4'b1011;
        busy_len = 3;
        clear_log();
        pulse_tick();
        wait_idle(200);
        check("t2_n_starts", log_car.size(), 3);
        if (log_car.size() == 3) begin
            check("t2_car_a", log_car[0], 0);
            check("t2_cmd_a", log_cmd[0], 1);
            check("t2_car_b", log_car[1], 1);
            check("t2_cmd_b", log_cmd[1], 2);
            check("t2_car_c", log_car[2], 3);
            check("t2_cmd_c", log_cmd[2], 4);
        end

        // ---- overrun during WAIT_DONE, set beats clear ----
        mask     = 4'b0100;
        busy_len = 20;
        clear_log();
        pulse_tick();
        step(3);                            // WAIT_DONE for car 2
        check("t3_overrun_before", {31'd0, overrun}, 0);
        pulse_tick();
        check("t3_overrun_set", {31'd0, overrun}, 1);
        tick = 1'b1;
        clr  = 1'b1;
        step(1);
        tick = 1'b0;
        clr  = 1'b0;
        check("t3_set_beats_clr", {31'd0, overrun}, 1);
        clr = 1'b1;
        step(1);
        clr = 1'b0;
        check("t3_overrun_cleared", {31'd0, overrun}, 0);
        wait_idle(100);
        step(5);
        check("t3_no_extra_round", log_car.size(), 1);

        // ---- transmitter never goes busy ----
        busy_en = 0;
        mask    = 4'b0011;
        clear_log();
        pulse_tick();
        step(1);
        check("t4_start_car0", {31'd0, tx_start}, 1);
        check("t4_car0", {30'd0, tx_car}, 0);
        step(16);
        check("t4_no_ack_not_yet", {31'd0, no_ack}, 0);
        step(1);
        check("t4_no_ack_set", {31'd0, no_ack}, 1);
        step(1);
        check("t4_start_car1", {31'd0, tx_start}, 1);
        check("t4_car1", {30'd0, tx_car}, 1);
        wait_idle(100);
        clr = 1'b1;
        step(1);
        clr = 1'b0;
        check("t4_no_ack_cleared", {31'd0, no_ack}, 0);

        // ---- watchdog ----
        busy_en  = 1;
        busy_len = 3;
        mask     = 4'b0000;
        write_cmd(1, 9);
        for (int i = 0; i < 8; i++) begin
            pulse_tick();
            step(1);
        end
        mask = 4'b0010;                     // 9th tick: still alive
        clear_log();
        pulse_tick();
        wait_idle(100);
        check("t5_alive_n", log_cmd.size(), 1);
        if (log_cmd.size() == 1) check("t5_alive_cmd", log_cmd[0], 9);
        mask = 4'b0000;                     // 10th tick: cleared
        pulse_tick();
        step(1);
        mask = 4'b0010;
        clear_log();
        pulse_tick();
        wait_idle(100);
        check("t5_expired_n", log_cmd.size(), 1);
        if (log_cmd.size() == 1) check("t5_expired_cmd", log_cmd[0], 0);
        mask = 4'b0000;
        write_cmd(1, 4'hA);
        for (int i = 0; i < 9; i++) begin
            pulse_tick();
            step(1);
        end
        wr_en  = 1'b1;                      // write on the 10th tick
        wr_car = 2'd1;
        wr_cmd = 4'hB;
        pulse_tick();
        wr_en  = 1'b0;
        mask   = 4'b0010;
        clear_log();
        pulse_tick();
        wait_idle(100);
        check("t5_write_wins_n", log_cmd.size(), 1);
        if (log_cmd.size() == 1) check("t5_write_wins_cmd", log_cmd[0], 4'hB);

        // ---- async reset in WAIT_DONE ----
        write_cmd(2, 5);
        mask     = 4'b0100;
        busy_len = 20;
        pulse_tick();
        step(3);
        pulse_tick();
        check("t6_pre_overrun", {31'd0, overrun}, 1);
        check("t6_pre_car", {30'd0, tx_car}, 2);
        rst_n = 1'b0;
        #1;
        check("t6_rst_car", {30'd0, tx_car}, 0);
        check("t6_rst_cmd", {28'd0, tx_cmd}, 0);
        check("t6_rst_overrun", {31'd0, overrun}, 0);
        check("t6_rst_ra", {31'd0, round_active}, 0);
        step(2);
        rst_n = 1'b1;
        step(1);
        busy_len = 3;
        mask     = 4'b0101;
        clear_log();
        pulse_tick();
        wait_idle(100);
        check("t6_n_starts", log_car.size(), 2);
        if (log_car.size() == 2) begin
            check("t6_car_a", log_car[0], 0);
            check("t6_cmd_a", log_cmd[0], 0);
            check("t6_car_b", log_car[1], 2);
            check("t6_cmd_b", log_cmd[1], 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
